// File: rtl/s2p_pkg.sv
// s2p_pkg: shared FSM states, rate-mode codes and block size for the Serial2Parallel frame controller
package s2p_pkg;
  typedef enum logic [2:0] {IDLE, FILL, STREAM, DRAIN, DONE} stateT;
  localparam logic [1:0] MODE_R12 = 2'd0;
  localparam logic [1:0] MODE_R34 = 2'd1;
  localparam logic [1:0] MODE_R23 = 2'd2;
  localparam int BLOCK_BITS = 12;
endpackage

// File: rtl/s2p_rate_lut.sv
// s2p_rate_lut: registered frame length in bits and output pairs from a block count, loaded on an accepted start
module s2p_rate_lut
  import s2p_pkg::*;
#(
  parameter int LEN_W = 8,
  parameter int CNT_W = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [1:0]       mode,
  input  logic [LEN_W-1:0] lenBlocks,
  output logic [CNT_W-1:0] bits,
  output logic [CNT_W-1:0] pairs
);
  logic [CNT_W-1:0] k;
  assign k = CNT_W'(lenBlocks);
  // bits = 12k, pairs = 6k / 9k / 8k, built from shifts and adds only
  always_ff @(posedge clock) begin
    if (!reset) begin
      bits  <= '0;
      pairs <= '0;
    end else if (load) begin
      bits  <= (k << 3) + (k << 2);
      pairs <= mode == MODE_R12 ? (k << 2) + (k << 1) :
               mode == MODE_R34 ? (k << 3) + k : k << 3;
    end
  end
endmodule

// File: rtl/s2p_frame_ctrl.sv
// s2p_frame_ctrl: frame sequencer gating serial input and pacing reads of Serial2Parallel; optional watchdog under S2P_CTRL_TIMEOUT_EN
module s2p_frame_ctrl
  import s2p_pkg::*;
#(
  parameter int LEN_W = 8,
  parameter int CNT_W = 12
`ifdef S2P_CTRL_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 256
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode_in,
  input  logic [LEN_W-1:0] len_blocks,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             src_valid,
  output logic             src_ready,
  output logic [1:0]       s2p_mode,
  output logic             s2p_data_in_valid,
  output logic             s2p_read_en,
  input  logic             s2p_data_out_valid,
  input  logic             sink_ready
);
  stateT            state, nextState;
  logic [CNT_W-1:0] inCnt, rdCnt, outCnt, inNext, outNext, bitsLen, pairsLen;
  logic             startOk, load, streaming, outHit, readNext, wdFire;

  assign startOk           = start && mode_in != 2'd3 && len_blocks != '0;
  assign load              = state == IDLE && startOk;
  assign streaming         = state == STREAM || state == DRAIN;
  assign s2p_data_in_valid = src_valid & src_ready;
  assign outHit            = streaming && s2p_data_out_valid && outCnt < pairsLen;
  assign inNext            = inCnt + CNT_W'(s2p_data_in_valid);
  assign outNext           = outCnt + CNT_W'(outHit);

  s2p_rate_lut #(.LEN_W(LEN_W), .CNT_W(CNT_W)) rateLut (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .mode     (mode_in),
    .lenBlocks(len_blocks),
    .bits     (bitsLen),
    .pairs    (pairsLen)
  );

`ifdef S2P_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wdCnt;
  logic            watching;
  assign watching = streaming && rdCnt != '0 && !s2p_data_out_valid;
  assign wdFire   = watching && wdCnt == WD_W'(TIMEOUT_CYC - 1);
  // watchdog: consecutive stalled cycles after the first read, cleared by any returned pair
  always_ff @(posedge clock) begin
    if (!reset) wdCnt <= '0;
    else wdCnt <= watching ? wdCnt + 1'b1 : '0;
  end
`else
  assign wdFire = 1'b0;
`endif

  // next state: fill to the pair count, stream until all bits are in, drain until all pairs are back
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (load) nextState = FILL;
      FILL:    if (inNext == pairsLen) nextState = STREAM;
      STREAM:  if (inNext == bitsLen) nextState = outNext == pairsLen ? DONE : DRAIN;
      DRAIN:   if (outNext == pairsLen) nextState = DONE;
      default: nextState = IDLE;
    endcase
    if (wdFire) nextState = IDLE;
  end

  assign readNext = (nextState == STREAM || nextState == DRAIN) && sink_ready && rdCnt < pairsLen;

  // state, counters and registered outputs; all outputs derive from the next state
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      src_ready   <= 1'b0;
      s2p_read_en <= 1'b0;
      s2p_mode    <= 2'd0;
      inCnt       <= '0;
      rdCnt       <= '0;
      outCnt      <= '0;
    end else begin
      state       <= nextState;
      busy        <= nextState != IDLE;
      done        <= nextState == DONE || wdFire;
      err         <= (state == IDLE && start && !startOk) || wdFire;
      src_ready   <= nextState == FILL || nextState == STREAM;
      s2p_read_en <= readNext;
      inCnt       <= load ? '0 : inNext;
      rdCnt       <= load ? '0 : rdCnt + CNT_W'(readNext);
      outCnt      <= load ? '0 : outNext;
      if (load) s2p_mode <= mode_in;
    end
  end
endmodule
